// File: rtl/clock_time_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_time_controller
// Description : Sequencing controller for cascaded BCD time counters.
//               Seconds (mod-60), minutes (mod-60) and hours (mod-HR_MOD).
//               Advances time from a 1 Hz tick in RUN. Provides a
//               button-driven set mode (hours, then minutes) that takes
//               over the counter chain.
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous active-low reset
//               tick_1hz   - one-clk pulse per second
//               mode_btn   - debounced level, press = rising edge
//               inc_btn    - debounced level, press = rising edge
//               sec_bcd    - seconds BCD {tens, units}
//               min_bcd    - minutes BCD {tens, units}
//               hr_bcd     - hours BCD {tens, units}
//               state      - 0=RUN, 1=SET_HR, 2=SET_MIN
//               blink      - show (1) / blank (0) for the field being set
//               min_carry  - 1-clk pulse on seconds wrap in RUN
//               hr_carry   - 1-clk pulse on minutes wrap in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module clock_time_controller #(
    parameter int HR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic [1:0] state,
    output logic       blink,
    output logic       min_carry,
    output logic       hr_carry
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    // Last legal value of each field, in BCD.
    localparam logic [7:0] c_ms_last_bcd = 8'h59;
    localparam logic [7:0] c_hr_last_bcd = {4'((HR_MOD - 1) / 10), 4'((HR_MOD - 1) % 10)};

    state_t     r_state;
    state_t     w_state_next;
    logic       r_mode_q;
    logic       r_inc_q;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] r_hr;
    logic       r_blink;
    logic       r_min_carry;
    logic       r_hr_carry;
    logic       w_mode_press;
    logic       w_inc_press;

    // BCD increment with wrap to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign w_mode_press = mode_btn & ~r_mode_q;
    assign w_inc_press  = inc_btn  & ~r_inc_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: only a mode press moves the FSM.
    always_comb begin
        w_state_next = r_state;
        if (w_mode_press) begin
            case (r_state)
                ST_RUN:     w_state_next = ST_SET_HR;
                ST_SET_HR:  w_state_next = ST_SET_MIN;
                ST_SET_MIN: w_state_next = ST_RUN;
                default:    w_state_next = ST_RUN;
            endcase
        end
    end

    // Time registers, button history, blink and carries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // History resets high so a button held through reset is not a press.
            r_mode_q    <= 1'b1;
            r_inc_q     <= 1'b1;
            r_sec       <= 8'h00;
            r_min       <= 8'h00;
            r_hr        <= 8'h00;
            r_blink     <= 1'b1;
            r_min_carry <= 1'b0;
            r_hr_carry  <= 1'b0;
        end else begin
            r_mode_q    <= mode_btn;
            r_inc_q     <= inc_btn;
            r_min_carry <= 1'b0;
            r_hr_carry  <= 1'b0;
            if (w_mode_press) begin
                // Mode has priority: any coincident tick or inc is dropped.
                r_blink <= 1'b1;
                if (r_state == ST_SET_MIN) begin
                    r_sec <= 8'h00;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_blink <= 1'b1;
                        if (tick_1hz) begin
                            r_sec <= bcd_inc(r_sec, c_ms_last_bcd);
                            if (r_sec == c_ms_last_bcd) begin
                                r_min       <= bcd_inc(r_min, c_ms_last_bcd);
                                r_min_carry <= 1'b1;
                                if (r_min == c_ms_last_bcd) begin
                                    r_hr       <= bcd_inc(r_hr, c_hr_last_bcd);
                                    r_hr_carry <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_SET_HR: begin
                        if (w_inc_press) begin
                            r_hr <= bcd_inc(r_hr, c_hr_last_bcd);
                        end
                        if (tick_1hz) begin
                            r_blink <= ~r_blink;
                        end
                    end
                    ST_SET_MIN: begin
                        if (w_inc_press) begin
                            r_min <= bcd_inc(r_min, c_ms_last_bcd);
                        end
                        if (tick_1hz) begin
                            r_blink <= ~r_blink;
                        end
                    end
                    default: begin
                        r_blink <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sec_bcd   = r_sec;
    assign min_bcd   = r_min;
    assign hr_bcd    = r_hr;
    assign state     = r_state;
    assign blink     = r_blink;
    assign min_carry = r_min_carry;
    assign hr_carry  = r_hr_carry;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_time_controller
// Description : Self-checking bench for clock_time_controller. A vector
//               table covers per-cycle behaviour; hand-written sequences
//               cover long wraps, set mode, blink and reset corner cases.
//               A second instance with HR_MOD=12 shares all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] sec_bcd, min_bcd, hr_bcd;
    logic [1:0] state;
    logic       blink, min_carry, hr_carry;
    logic [7:0] sec12, min12, hr12;
    logic [1:0] state12;
    logic       blink12, mc12, hc12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clock_time_controller #(.HR_MOD(24)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
        .state(state), .blink(blink), .min_carry(min_carry), .hr_carry(hr_carry)
    );

    clock_time_controller #(.HR_MOD(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .sec_bcd(sec12), .min_bcd(min12), .hr_bcd(hr12),
        .state(state12), .blink(blink12), .min_carry(mc12), .hr_carry(hc12)
    );

    typedef struct packed {
        logic       rst_n;
        logic       tick;
        logic       mode;
        logic       inc;
        logic [7:0] sec;
        logic [7:0] mn;
        logic [7:0] hr;
        logic [1:0] st;
        logic       blink;
        logic       mc;
        logic       hc;
    } vec_t;

    localparam int c_nvec = 20;
    vec_t vecs [c_nvec];

    function automatic vec_t mk(input logic r, t, m, i, input logic [7:0] s, mn, h,
                                input logic [1:0] st, input logic b, mc, hc);
        vec_t v;
        v.rst_n = r; v.tick = t; v.mode = m; v.inc = i;
        v.sec = s; v.mn = mn; v.hr = h; v.st = st; v.blink = b; v.mc = mc; v.hc = hc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs are stable 1 time unit later.
    task automatic cyc(input logic t, input logic m, input logic i);
        tick_1hz = t;
        mode_btn = m;
        inc_btn  = i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic press_mode();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0);
        end
    endtask

    initial begin
        int pulses;
        int pulse_at;
        logic [31:0] b_exp;

        //              rst t  m  i  sec    min    hr     st    b  mc hc
        vecs[0]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0); // reset
        vecs[1]  = mk(1, 1, 0, 0, 8'h01, 8'h00, 8'h00, 2'd0, 1, 0, 0); // tick
        vecs[2]  = mk(1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 2'd0, 1, 0, 0); // idle
        vecs[3]  = mk(1, 1, 1, 0, 8'h01, 8'h00, 8'h00, 2'd1, 1, 0, 0); // mode+tick: tick dropped
        vecs[4]  = mk(1, 0, 1, 1, 8'h01, 8'h00, 8'h01, 2'd1, 1, 0, 0); // inc, mode held
        vecs[5]  = mk(1, 1, 1, 0, 8'h01, 8'h00, 8'h01, 2'd1, 0, 0, 0); // tick toggles blink
        vecs[6]  = mk(1, 1, 1, 1, 8'h01, 8'h00, 8'h02, 2'd1, 1, 0, 0); // inc + tick
        vecs[7]  = mk(1, 1, 0, 0, 8'h01, 8'h00, 8'h02, 2'd1, 0, 0, 0); // tick
        vecs[8]  = mk(1, 0, 1, 1, 8'h01, 8'h00, 8'h02, 2'd2, 1, 0, 0); // mode+inc: mode wins
        vecs[9]  = mk(1, 0, 1, 0, 8'h01, 8'h00, 8'h02, 2'd2, 1, 0, 0); // idle
        vecs[10] = mk(1, 0, 1, 1, 8'h01, 8'h01, 8'h02, 2'd2, 1, 0, 0); // inc min
        vecs[11] = mk(1, 1, 1, 0, 8'h01, 8'h01, 8'h02, 2'd2, 0, 0, 0); // tick: sec frozen
        vecs[12] = mk(1, 0, 0, 0, 8'h01, 8'h01, 8'h02, 2'd2, 0, 0, 0); // idle
        vecs[13] = mk(1, 0, 1, 0, 8'h00, 8'h01, 8'h02, 2'd0, 1, 0, 0); // back to RUN, sec cleared
        vecs[14] = mk(1, 1, 1, 1, 8'h01, 8'h01, 8'h02, 2'd0, 1, 0, 0); // inc ignored in RUN
        vecs[15] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0); // reset
        vecs[16] = mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0); // mode held in reset
        vecs[17] = mk(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0); // release: no press
        vecs[18] = mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0); // release button
        vecs[19] = mk(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0); // genuine press

        for (int v = 0; v < c_nvec; v++) begin
            rst_n = vecs[v].rst_n;
            cyc(vecs[v].tick, vecs[v].mode, vecs[v].inc);
            chk($sformatf("vec%0d", v),
                {3'b0, sec_bcd, min_bcd, hr_bcd, state, blink, min_carry, hr_carry},
                {3'b0, vecs[v].sec, vecs[v].mn, vecs[v].hr, vecs[v].st,
                 vecs[v].blink, vecs[v].mc, vecs[v].hc});
        end

        // 61 ticks from reset: one min_carry, right after the 60th tick.
        do_reset();
        cyc(0, 0, 0);
        pulses = 0;
        pulse_at = 0;
        for (int k = 1; k <= 61; k++) begin
            cyc(1, 0, 0);
            if (min_carry) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("t61_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h0000_0101);
        chk("t61_pulses", pulses, 1);
        chk("t61_pulse_at", pulse_at, 60);

        // Set mode wrap checks: 25 incs on hours wraps at 24; 61 on minutes.
        do_reset();
        cyc(0, 0, 0);
        press_mode();
        press_inc(25);
        chk("set_hr_wrap", {24'h0, hr_bcd}, 32'h01);
        press_mode();
        press_inc(61);
        chk("set_min_wrap", {16'h0, hr_bcd, min_bcd}, 32'h0101);
        press_mode();
        chk("set_exit", {22'h0, state, sec_bcd}, {22'h0, 2'd0, 8'h00});

        // Blink in SET_HR over 5 ticks, seconds frozen.
        do_reset();
        cyc(0, 0, 0);
        ticks(3);
        press_mode();
        b_exp = 32'h0;
        b_exp[5] = blink;
        for (int k = 4; k >= 0; k--) begin
            cyc(1, 0, 0);
            b_exp[k] = blink;
        end
        chk("blink_seq", b_exp, 32'b101010);
        chk("set_sec_frozen", {24'h0, sec_bcd}, 32'h03);
        press_mode();
        press_mode();
        b_exp = 32'h0;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            b_exp[k] = blink;
        end
        chk("run_blink", b_exp, 32'hF);

        // 23:59 -> 00:00:00 (HR_MOD=24) and 11:59 -> 00:00:00 (HR_MOD=12).
        do_reset();
        cyc(0, 0, 0);
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        chk("preload_2359", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h0023_5900);
        ticks(59);
        chk("pre_wrap", {6'h0, min_carry, hr_carry, hr_bcd, min_bcd, sec_bcd}, 32'h0023_5959);
        cyc(1, 0, 0);
        chk("day_wrap", {6'h0, min_carry, hr_carry, hr_bcd, min_bcd, sec_bcd}, 32'h0300_0000);
        cyc(0, 0, 0);
        chk("carry_clear", {30'h0, min_carry, hr_carry}, 32'h0);

        do_reset();
        cyc(0, 0, 0);
        press_mode();
        press_inc(11);
        press_mode();
        press_inc(59);
        press_mode();
        chk("preload_1159_12", {8'h0, hr12, min12, sec12}, 32'h0011_5900);
        ticks(60);
        chk("wrap_12", {6'h0, mc12, hc12, hr12, min12, sec12}, 32'h0300_0000);
        chk("wrap_24_at_12", {6'h0, min_carry, hr_carry, hr_bcd, min_bcd, sec_bcd}, 32'h0312_0000);

        // Reset in the middle of SET_MIN at 14:37.
        do_reset();
        cyc(0, 0, 0);
        press_mode();
        press_inc(14);
        press_mode();
        press_inc(37);
        chk("preload_1437", {14'h0, state, hr_bcd, min_bcd}, {14'h0, 2'd2, 8'h14, 8'h37});
        do_reset();
        chk("reset_mid_set", {6'h0, state, hr_bcd, min_bcd, sec_bcd}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
